// File: rtl/mode_sequencer.sv
// Mode selector: two debounced active-low buttons step a mode index (with auto-repeat)
// and drive the matching active-low 7-segment glyph.
module mode_sequencer #(
    parameter int NUM_MODES     = 4,
    parameter int RESET_MODE    = 0,
    parameter int WRAP          = 1,
    parameter int DEBOUNCE_CYC  = 50000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 10000000,
    localparam int MW = (NUM_MODES <= 2) ? 1 : $clog2(NUM_MODES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          key_next,
    input  logic          key_prev,
    input  logic          mode_lock,
    output logic [MW-1:0] mode,
    output logic          mode_chg,
    output logic [7:0]    hex5
);

    localparam int DBW     = (DEBOUNCE_CYC < 2) ? 1 : $clog2(DEBOUNCE_CYC + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = $clog2(RPT_MAX + 1);
    localparam logic [MW-1:0] LAST_MODE = MW'(NUM_MODES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HELD  = 2'd1;
    localparam logic [1:0] ST_RPT   = 2'd2;
    localparam logic [1:0] ST_BLOCK = 2'd3;

    function automatic logic [7:0] glyph(input logic [MW-1:0] m);
        logic [2:0] idx;
        idx = 3'(m);
        case (idx)
            3'd0:    glyph = 8'b10001000;
            3'd1:    glyph = 8'b11000111;
            3'd2:    glyph = 8'b11000110;
            3'd3:    glyph = 8'b11000001;
            3'd4:    glyph = 8'b10000011;
            3'd5:    glyph = 8'b10100001;
            3'd6:    glyph = 8'b10000110;
            default: glyph = 8'b10001110;
        endcase
    endfunction

    // bit 0 = NEXT, bit 1 = PREV throughout
    logic [1:0] key_raw;
    logic [1:0] db_lvl;
    logic [1:0] press;

    assign key_raw = {key_prev, key_next};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_key
            logic           sync1_reg;
            logic           sync2_reg;
            logic           db_reg;
            logic           db_d_reg;
            logic [DBW-1:0] db_cnt_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_reg  <= 1'b1;
                    sync2_reg  <= 1'b1;
                    db_reg     <= 1'b1;
                    db_d_reg   <= 1'b1;
                    db_cnt_reg <= '0;
                end else begin
                    sync1_reg <= key_raw[gi];
                    sync2_reg <= sync1_reg;
                    db_d_reg  <= db_reg;
                    if (sync2_reg == db_reg) begin
                        db_cnt_reg <= '0;
                    end else if (db_cnt_reg == DBW'(DEBOUNCE_CYC - 1)) begin
                        db_reg     <= sync2_reg;
                        db_cnt_reg <= '0;
                    end else begin
                        db_cnt_reg <= db_cnt_reg + 1'b1;
                    end
                end
            end

            assign db_lvl[gi] = db_reg;
            assign press[gi]  = db_d_reg & ~db_reg;
        end
    endgenerate

    logic [1:0]    state_reg, state_next;
    logic          dir_reg, dir_next;
    logic [RW-1:0] rpt_cnt_reg, rpt_cnt_next;
    logic          step;
    logic          step_dir;

    // Repeat counter holds 1 on the step edge, so a step fires exactly N cycles after the last one
    always_comb begin
        state_next   = state_reg;
        dir_next     = dir_reg;
        rpt_cnt_next = rpt_cnt_reg;
        step         = 1'b0;
        step_dir     = dir_reg;
        case (state_reg)
            ST_IDLE: begin
                if (press[0] ^ press[1]) begin
                    step         = 1'b1;
                    step_dir     = press[1];
                    dir_next     = press[1];
                    rpt_cnt_next = RW'(1);
                    state_next   = ST_HELD;
                end else if (press[0] & press[1]) begin
                    state_next = ST_BLOCK;
                end
            end
            ST_HELD: begin
                if (db_lvl[dir_reg]) begin
                    state_next = ST_IDLE;
                end else if (rpt_cnt_reg == RW'(REPEAT_DELAY)) begin
                    step         = 1'b1;
                    rpt_cnt_next = RW'(1);
                    state_next   = ST_RPT;
                end else begin
                    rpt_cnt_next = rpt_cnt_reg + 1'b1;
                end
            end
            ST_RPT: begin
                if (db_lvl[dir_reg]) begin
                    state_next = ST_IDLE;
                end else if (rpt_cnt_reg == RW'(REPEAT_PERIOD)) begin
                    step         = 1'b1;
                    rpt_cnt_next = RW'(1);
                end else begin
                    rpt_cnt_next = rpt_cnt_reg + 1'b1;
                end
            end
            ST_BLOCK: begin
                if (&db_lvl) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    logic [MW-1:0] mode_reg;
    logic [MW-1:0] mode_cand;
    logic          mode_chg_reg;
    logic [7:0]    hex_reg;
    logic          do_chg;

    always_comb begin
        mode_cand = mode_reg;
        if (!step_dir) begin
            if (mode_reg == LAST_MODE) begin
                mode_cand = (WRAP != 0) ? '0 : mode_reg;
            end else begin
                mode_cand = mode_reg + 1'b1;
            end
        end else begin
            if (mode_reg == '0) begin
                mode_cand = (WRAP != 0) ? LAST_MODE : mode_reg;
            end else begin
                mode_cand = mode_reg - 1'b1;
            end
        end
    end

    assign do_chg = step & ~mode_lock & (mode_cand != mode_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            dir_reg      <= 1'b0;
            rpt_cnt_reg  <= '0;
            mode_reg     <= MW'(RESET_MODE);
            hex_reg      <= glyph(MW'(RESET_MODE));
            mode_chg_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            dir_reg      <= dir_next;
            rpt_cnt_reg  <= rpt_cnt_next;
            mode_chg_reg <= do_chg;
            if (do_chg) begin
                mode_reg <= mode_cand;
                hex_reg  <= glyph(mode_cand);
            end
        end
    end

    assign mode     = mode_reg;
    assign mode_chg = mode_chg_reg;
    assign hex5     = hex_reg;

endmodule

// File: tb/tb_mode_sequencer.sv
// Bench for mode_sequencer: two configurations (4 modes wrapping, 5 modes saturating) share
// stimulus and are checked every cycle against a window/schedule-based reference model.
module tb_mode_sequencer;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_next = 1'b1;
    logic       key_prev = 1'b1;
    logic       mode_lock = 1'b0;
    logic [1:0] mode_a;
    logic [2:0] mode_b;
    logic       chg_a, chg_b;
    logic [7:0] hex_a, hex_b;

    always #5 clk = ~clk;

    mode_sequencer #(
        .NUM_MODES(4), .RESET_MODE(0), .WRAP(1),
        .DEBOUNCE_CYC(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .key_next(key_next), .key_prev(key_prev),
        .mode_lock(mode_lock), .mode(mode_a), .mode_chg(chg_a), .hex5(hex_a)
    );

    mode_sequencer #(
        .NUM_MODES(5), .RESET_MODE(0), .WRAP(0),
        .DEBOUNCE_CYC(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .key_next(key_next), .key_prev(key_prev),
        .mode_lock(mode_lock), .mode(mode_b), .mode_chg(chg_b), .hex5(hex_b)
    );

    int vecs = 0;
    int fails = 0;
    int pulses_a = 0;
    int pulses_b = 0;
    bit checking = 1'b0;

    logic [7:0] glyph_tab [8] = '{8'b10001000, 8'b11000111, 8'b11000110, 8'b11000001,
                                  8'b10000011, 8'b10100001, 8'b10000110, 8'b10001110};
    int nm [2] = '{4, 5};
    bit wr [2] = '{1'b1, 1'b0};

    // Reference model: debounced level flips once the last D synchronised samples all disagree;
    // repeats are scheduled as absolute cycle numbers.
    bit hist [2][D+1];
    bit mdb [2];
    bit mdb_old [2];
    int trk;        // 0 none, 1 next held, 2 prev held, 3 both pressed together
    int ncyc;
    int next_t;
    int mmode [2];
    bit mchg [2];

    task automatic chk(string name, int act, int exp);
        vecs++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i <= D; i++) hist[k][i] = 1'b1;
            mdb[k] = 1'b1;
            mdb_old[k] = 1'b1;
            mmode[k] = 0;
            mchg[k] = 1'b0;
        end
        trk = 0;
        ncyc = 0;
        next_t = 0;
    endtask

    task automatic model_step(int dir, bit lock);
        for (int u = 0; u < 2; u++) begin
            int nxt;
            if (dir > 0) nxt = (mmode[u] == nm[u] - 1) ? (wr[u] ? 0 : mmode[u]) : mmode[u] + 1;
            else         nxt = (mmode[u] == 0) ? (wr[u] ? nm[u] - 1 : 0) : mmode[u] - 1;
            if (!lock && nxt != mmode[u]) begin
                mmode[u] = nxt;
                mchg[u] = 1'b1;
            end
        end
    endtask

    task automatic model_edge(bit rn, bit rp, bit lock);
        bit press [2];
        bit raw [2];
        raw[0] = rn;
        raw[1] = rp;
        mchg[0] = 1'b0;
        mchg[1] = 1'b0;
        ncyc++;
        for (int k = 0; k < 2; k++) press[k] = mdb_old[k] & ~mdb[k];
        if (trk == 0) begin
            if (press[0] && !press[1]) begin
                model_step(1, lock); trk = 1; next_t = ncyc + RD;
            end else if (press[1] && !press[0]) begin
                model_step(-1, lock); trk = 2; next_t = ncyc + RD;
            end else if (press[0] && press[1]) begin
                trk = 3;
            end
        end else if (trk == 3) begin
            if (mdb[0] && mdb[1]) trk = 0;
        end else begin
            if (mdb[trk-1]) trk = 0;
            else if (ncyc == next_t) begin
                model_step(trk == 1 ? 1 : -1, lock);
                next_t = ncyc + RP;
            end
        end
        for (int k = 0; k < 2; k++) begin
            bit all_diff;
            mdb_old[k] = mdb[k];
            all_diff = 1'b1;
            for (int i = 1; i <= D; i++) if (hist[k][i] == mdb[k]) all_diff = 1'b0;
            if (all_diff) mdb[k] = ~mdb[k];
            for (int i = D; i >= 1; i--) hist[k][i] = hist[k][i-1];
            hist[k][0] = raw[k];
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_edge(key_next, key_prev, mode_lock);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (checking) begin
                chk("mode_a", int'(mode_a), mmode[0]);
                chk("chg_a", int'(chg_a), int'(mchg[0]));
                chk("hex_a", int'(hex_a), int'(glyph_tab[mmode[0]]));
                chk("mode_b", int'(mode_b), mmode[1]);
                chk("chg_b", int'(chg_b), int'(mchg[1]));
                chk("hex_b", int'(hex_b), int'(glyph_tab[mmode[1]]));
            end
            if (chg_a === 1'b1) pulses_a++;
            if (chg_b === 1'b1) pulses_b++;
        end
    end

    task automatic cycles(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tap(bit prev, int lo, int hi);
        if (prev) key_prev = 1'b0; else key_next = 1'b0;
        cycles(lo);
        if (prev) key_prev = 1'b1; else key_next = 1'b1;
        cycles(hi);
    endtask

    int pa, pb;

    initial begin
        cycles(3);
        #2 rst_n = 1'b1;
        checking = 1'b1;
        cycles(2);
        chk("reset_mode_a", int'(mode_a), 0);
        chk("reset_hex_a", int'(hex_a), 'b10001000);
        chk("reset_chg_a", int'(chg_a), 0);
        chk("reset_mode_b", int'(mode_b), 0);

        $display("tap NEXT x3");
        pa = pulses_a; pb = pulses_b;
        for (int i = 0; i < 3; i++) tap(1'b0, 10, 10);
        chk("taps_mode_a", int'(mode_a), 3);
        chk("taps_hex_a", int'(hex_a), 'b11000001);
        chk("taps_pulses_a", pulses_a - pa, 3);
        chk("taps_mode_b", int'(mode_b), 3);

        $display("tap NEXT then PREV across the wrap point");
        tap(1'b0, 10, 10);
        chk("wrap_up_mode_a", int'(mode_a), 0);
        chk("wrap_up_hex_a", int'(hex_a), 'b10001000);
        chk("sat_up_mode_b", int'(mode_b), 4);
        tap(1'b1, 10, 10);
        chk("wrap_dn_mode_a", int'(mode_a), 3);
        chk("dn_mode_b", int'(mode_b), 3);

        $display("glitch NEXT");
        pa = pulses_a;
        for (int i = 0; i < 5; i++) tap(1'b0, 3, 2);
        cycles(10);
        chk("glitch_mode_a", int'(mode_a), 3);
        chk("glitch_pulses_a", pulses_a - pa, 0);

        $display("hold NEXT for auto-repeat");
        tap(1'b0, 10, 10);
        pa = pulses_a; pb = pulses_b;
        tap(1'b0, 60, 30);
        chk("repeat_mode_a", int'(mode_a), 2);
        chk("repeat_pulses_a", pulses_a - pa, 6);
        chk("repeat_mode_b", int'(mode_b), 4);
        chk("repeat_pulses_b", pulses_b - pb, 0);

        $display("press both keys together");
        pa = pulses_a;
        key_next = 1'b0; key_prev = 1'b0;
        cycles(30);
        key_next = 1'b1; key_prev = 1'b1;
        cycles(15);
        chk("both_pulses_a", pulses_a - pa, 0);

        $display("hold PREV, press NEXT meanwhile");
        pa = pulses_a; pb = pulses_b;
        key_prev = 1'b0;
        cycles(5);
        key_next = 1'b0;
        cycles(12);
        key_next = 1'b1;
        cycles(8);
        key_prev = 1'b1;
        cycles(15);
        chk("prevhold_mode_a", int'(mode_a), 0);
        chk("prevhold_pulses_a", pulses_a - pa, 2);
        chk("prevhold_mode_b", int'(mode_b), 2);

        $display("tap NEXT with mode_lock");
        pa = pulses_a;
        mode_lock = 1'b1;
        tap(1'b0, 10, 10);
        mode_lock = 1'b0;
        chk("lock_mode_a", int'(mode_a), 0);
        chk("lock_pulses_a", pulses_a - pa, 0);

        $display("saturating hold then reset mid-hold");
        #2 rst_n = 1'b0;
        cycles(2);
        #2 rst_n = 1'b1;
        cycles(2);
        pb = pulses_b;
        key_next = 1'b0;
        cycles(80);
        chk("sat_mode_b", int'(mode_b), 4);
        chk("sat_pulses_b", pulses_b - pb, 4);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_mode_b", int'(mode_b), 0);
        chk("async_rst_hex_b", int'(hex_b), 'b10001000);
        chk("async_rst_mode_a", int'(mode_a), 0);
        cycles(3);
        #2 rst_n = 1'b1;
        cycles(4);
        chk("held_after_rst_b", int'(mode_b), 0);
        cycles(5);
        chk("redebounced_step_b", int'(mode_b), 1);
        key_next = 1'b1;
        cycles(15);

        for (int s = 0; s < 150; s++) begin
            int dur;
            key_next = ($urandom_range(0, 2) == 0);
            key_prev = ($urandom_range(0, 2) != 0);
            mode_lock = ($urandom_range(0, 5) == 0);
            dur = $urandom_range(1, 40);
            $display("seg %0d: next=%0b prev=%0b lock=%0b for %0d cycles", s, key_next, key_prev, mode_lock, dur);
            if ($urandom_range(0, 49) == 0) begin
                #2 rst_n = 1'b0;
                cycles(2);
                #2 rst_n = 1'b1;
            end
            cycles(dur);
        end
        key_next = 1'b1; key_prev = 1'b1; mode_lock = 1'b0;
        cycles(20);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
